// File: rtl/scrambler_pcie_nbyte.sv
// PCIe Gen1/Gen2 scrambler/descrambler, BYTES symbols per clock, per-byte K flags.
// Latency 1 clk (2 clk when SCRAMBLER_PIPE_EN is defined); one beat per clock.
// No backpressure: every valid_in beat is accepted; idle cycles hold the LFSR.
//
// Optional build macro: SCRAMBLER_PIPE_EN adds a second output register stage.
// lfsr_state still updates one cycle after each accepted beat.
//
// Ports:
//   clk, rst_b                    clock, asynchronous active-low reset
//   valid_in, din, k_in           input beat: BYTES symbols, byte 0 earliest in time
//   dis_scrambler_in              bypass the XOR for this beat; the LFSR still runs
//   valid_out, dout, k_out        output beat, aligned with the data
//   dis_scrambler_out             dis_scrambler_in, aligned with the data
//   lfsr_state                    LFSR value after the last accepted beat (debug)
// Legal BYTES values: 1, 2, 4.
module scrambler_pcie_nbyte #(
  parameter int          BYTES = 1,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 valid_in,
  input  logic [8*BYTES-1:0]   din,
  input  logic [BYTES-1:0]     k_in,
  input  logic                 dis_scrambler_in,
  output logic                 valid_out,
  output logic [8*BYTES-1:0]   dout,
  output logic [BYTES-1:0]     k_out,
  output logic                 dis_scrambler_out,
  output logic [15:0]          lfsr_state
);

  localparam logic [7:0]  COM_SYM = 8'hBC;
  localparam logic [7:0]  SKP_SYM = 8'h1C;
  // Galois taps for x^16+x^5+x^4+x^3+1.
  localparam logic [15:0] TAPS    = 16'h0039;

  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_nxt;
  logic [15:0]        lfsr_c;
  logic [15:0]        step_c;
  logic [7:0]         ks_c;
  logic [7:0]         byte_c;
  logic [8*BYTES-1:0] dout_c;

  // Byte lanes are chained in time order: each lane starts from the LFSR
  // value left by the previous lane, so a COM in lane i reseeds lanes > i.
  always_comb begin
    lfsr_c = lfsr_q;
    dout_c = '0;
    step_c = '0;
    ks_c   = '0;
    byte_c = '0;
    for (int b = 0; b < BYTES; b++) begin
      byte_c = din[8*b +: 8];
      step_c = lfsr_c;
      for (int j = 0; j < 8; j++) begin
        ks_c[j] = step_c[15];
        step_c  = {step_c[14:0], 1'b0} ^ (step_c[15] ? TAPS : 16'h0000);
      end
      if (k_in[b] && (byte_c == COM_SYM)) begin
        dout_c[8*b +: 8] = byte_c;
        lfsr_c           = SEED;
      end else if (k_in[b] && (byte_c == SKP_SYM)) begin
        // SKPs may be added/removed by retimers, so they must not move the LFSR.
        dout_c[8*b +: 8] = byte_c;
      end else begin
        // Bypass keeps advancing the LFSR so re-enabling stays in lock-step
        // with the far end.
        dout_c[8*b +: 8] = (k_in[b] || dis_scrambler_in) ? byte_c : (byte_c ^ ks_c);
        lfsr_c           = step_c;
      end
    end
    lfsr_nxt = lfsr_c;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lfsr_q <= SEED;
    end else if (valid_in) begin
      lfsr_q <= lfsr_nxt;
    end
  end

  assign lfsr_state = lfsr_q;

  // First output stage: data registers hold on idle cycles.
  logic               vld_s1;
  logic [8*BYTES-1:0] dout_s1;
  logic [BYTES-1:0]   k_s1;
  logic               dis_s1;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_s1  <= 1'b0;
      dout_s1 <= '0;
      k_s1    <= '0;
      dis_s1  <= 1'b0;
    end else begin
      vld_s1 <= valid_in;
      if (valid_in) begin
        dout_s1 <= dout_c;
        k_s1    <= k_in;
        dis_s1  <= dis_scrambler_in;
      end
    end
  end

`ifdef SCRAMBLER_PIPE_EN
  logic               vld_s2;
  logic [8*BYTES-1:0] dout_s2;
  logic [BYTES-1:0]   k_s2;
  logic               dis_s2;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_s2  <= 1'b0;
      dout_s2 <= '0;
      k_s2    <= '0;
      dis_s2  <= 1'b0;
    end else begin
      vld_s2 <= vld_s1;
      if (vld_s1) begin
        dout_s2 <= dout_s1;
        k_s2    <= k_s1;
        dis_s2  <= dis_s1;
      end
    end
  end

  assign valid_out         = vld_s2;
  assign dout              = dout_s2;
  assign k_out             = k_s2;
  assign dis_scrambler_out = dis_s2;
`else
  assign valid_out         = vld_s1;
  assign dout              = dout_s1;
  assign k_out             = k_s1;
  assign dis_scrambler_out = dis_s1;
`endif

endmodule
